// File: rtl/rom_fetch_ctrl_pkg.sv
// rom_fetch_ctrl_pkg: shared types and constants for the ROM fetch responder.
//   fetch_state_e : fill FSM encoding (IDLE/FILL/LAST)
//   ZERO_WORD     : value driven on rom_rdata whenever it is not valid
package rom_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    LAST = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ZERO_WORD      = 32'h0;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction-fetch responder for the core ROM port.
// Serves 32-bit words assembled little-endian from a byte-wide synchronous
// memory, with a one-word hit buffer that answers repeat fetches in 0 cycles.
// Ports:
//   clk, rst            clock, async active-low reset
//   rom_ce, rom_raddr   fetch request (byte address, bits [1:0] ignored)
//   rom_rdata, rom_ready  instruction word (0 unless ready), valid flag
//   flush               invalidate hit buffer (memory reloaded)
//   mem_re, mem_addr    byte read strobe / byte address to backing memory
//   mem_rdata           byte returned one cycle after mem_re
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce,
  input  logic [ADDR_W-1:0]     rom_raddr,
  output logic [31:0]           rom_rdata,
  output logic                  rom_ready,
  input  logic                  flush,
  output logic                  mem_re,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rdata
);

  localparam int TAG_W = ADDR_W - 2;

  fetch_state_e     state, state_nxt;
  logic             buf_valid;
  logic [TAG_W-1:0] buf_tag;
  logic [31:0]      buf_data;
  logic [TAG_W-1:0] fill_tag;
  logic [1:0]       k;
  logic [1:0]       k_prev;
  logic             poison;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             unused_addr_lsb;

  assign req_tag         = rom_raddr[ADDR_W-1:2];
  assign unused_addr_lsb = ^rom_raddr[1:0];
  assign k_prev          = k - 2'd1;

  // flush takes priority over a hit in the same cycle
  assign hit = rom_ce & buf_valid & (req_tag == buf_tag) & (state == IDLE) & ~flush;

  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_addr  = '0;
    rom_ready = 1'b0;
    rom_rdata = ZERO_WORD;
    case (state)
      IDLE: begin
        if (hit) begin
          rom_ready = 1'b1;
          rom_rdata = buf_data;
        end else if (rom_ce) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        mem_re   = 1'b1;
        // {tag,2'b00}+k with k<4 is just the concatenation; upper tag bits
        // fall off, so the memory address wraps modulo 2^MEM_ADDR_W
        mem_addr = {fill_tag[MEM_ADDR_W-3:0], k};
        if (k == 2'd3) state_nxt = LAST;
      end
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= ZERO_WORD;
      fill_tag  <= '0;
      k         <= 2'd0;
      poison    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (rom_ce && !hit) begin
            fill_tag <= req_tag;
            k        <= 2'd0;
          end
        end
        FILL: begin
          k <= k + 2'd1;
          // byte for strobe k-1 lands now; nothing to capture on the first strobe
          if (k != 2'd0) buf_data[{k_prev, 3'b000} +: 8] <= mem_rdata;
        end
        LAST: begin
          buf_data[31:24] <= mem_rdata;
          buf_tag         <= fill_tag;
          buf_valid       <= ~poison;
        end
        default: ;
      endcase

      // a flush seen while a fill is in flight must not let that fill validate
      if (flush && state != IDLE) poison <= 1'b1;
      if (state == LAST)          poison <= 1'b0;
      if (flush)                  buf_valid <= 1'b0;
    end
  end

endmodule
